// File: rtl/quad_dec.sv
`default_nettype none
// ============================================================================
//  Module   : quad_dec
//  Brief    : Quadrature A/B decoder with W-bit wrapping up/down position
//             count, ROM-based transition decode and a warm-up FSM that
//             keeps the reset contents of the synchronizer from being decoded.
//  Revision : 1.0  initial release
// ============================================================================
module quad_dec #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         A,
  input  logic         B,
  output logic [W-1:0] Q,
  output logic         DIR,
  output logic         STEP,
  output logic         ERR
);

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    WARM2 = 2'd2,
    RUN   = 2'd3
  } state_t;

  logic [1:0]   r_s1;
  logic [1:0]   r_s2;
  logic [1:0]   r_prev;
  state_t       r_state;
  logic [W-1:0] r_q;
  logic         r_dir;
  logic         r_step;
  logic         r_err;

  logic [2:0]   w_rom;
  logic         w_step;
  logic         w_dir;
  logic         w_err;

  // Two-stage synchronizer for the asynchronous phases, plus the previous
  // synchronized sample that forms the upper half of the ROM address.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_s1   <= 2'b00;
      r_s2   <= 2'b00;
      r_prev <= 2'b00;
    end else begin
      r_s1   <= {A, B};
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Transition decode ROM: {prev, cur} -> {step, dir, err}.
  always_comb begin
    w_rom = 3'b000;
    case ({r_prev, r_s2})
      // forward 00->01->11->10->00
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rom = 3'b100;
      // reverse 00->10->11->01->00
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_rom = 3'b110;
      // double transitions, both phases changed in one sample
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_rom = 3'b001;
      // idle: prev == cur
      default:                            w_rom = 3'b000;
    endcase
  end

  assign w_step = w_rom[2];
  assign w_dir  = w_rom[1];
  assign w_err  = w_rom[0];

  // Warm-up sequencing and registered position/direction/step/error outputs;
  // decode results are only acted on once the FSM has reached RUN.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= WARM0;
      r_q     <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        WARM0:   r_state <= WARM1;
        WARM1:   r_state <= WARM2;
        WARM2:   r_state <= RUN;
        default: r_state <= RUN;
      endcase

      if (r_state == RUN) begin
        r_step <= w_step;
        r_err  <= r_err | w_err;
        if (w_step) begin
          r_dir <= w_dir;
          if (w_dir) begin
            r_q <= r_q - W'(1);
          end else begin
            r_q <= r_q + W'(1);
          end
        end
      end
    end
  end

  assign Q    = r_q;
  assign DIR  = r_dir;
  assign STEP = r_step;
  assign ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_dec
//  Brief    : Self-checking bench for quad_dec (W = 4) with a result queue
//             filled at stimulus time and drained when outputs are due.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quad_dec;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         A   = 1'b0;
  logic         B   = 1'b0;
  logic [W-1:0] Q;
  logic         DIR;
  logic         STEP;
  logic         ERR;

  typedef struct {
    logic [W-1:0] q;
    logic         dir;
    logic         step;
    logic         err;
  } exp_t;

  exp_t         sb[$];

  int           n_total = 0;
  int           n_pass  = 0;

  logic [W-1:0] m_q   = '0;
  logic         m_dir = 1'b0;
  logic         m_err = 1'b0;
  logic [1:0]   m_ab  = 2'b00;

  quad_dec #(.W(W)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .DIR  (DIR),
    .STEP (STEP),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  // Position of an AB value along the forward Gray cycle 00,01,11,10.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Drive one new AB value, predict the result, then check latency and
  // the outputs two edges later, and that STEP falls one edge after that.
  task automatic move(input logic [1:0] ab, input string tag);
    exp_t         e;
    logic [1:0]   d;
    logic [W-1:0] q_before;
    q_before = m_q;
    d = phase(ab) - phase(m_ab);
    e.step = 1'b0;
    if (d == 2'd1) begin
      m_q = m_q + W'(1); m_dir = 1'b0; e.step = 1'b1;
    end else if (d == 2'd3) begin
      m_q = m_q - W'(1); m_dir = 1'b1; e.step = 1'b1;
    end else if (d == 2'd2) begin
      m_err = 1'b1;
    end
    e.q = m_q; e.dir = m_dir; e.err = m_err;
    sb.push_back(e);
    m_ab = ab;
    {A, B} = ab;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk({tag, "_q_early"}, 32'(Q), 32'(q_before));
    chk({tag, "_step_early"}, 32'(STEP), 32'd0);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk({tag, "_q"}, 32'(Q), 32'(e.q));
    chk({tag, "_dir"}, 32'(DIR), 32'(e.dir));
    chk({tag, "_step"}, 32'(STEP), 32'(e.step));
    chk({tag, "_err"}, 32'(ERR), 32'(e.err));
    @(posedge CLK); #1;
    chk({tag, "_step_off"}, 32'(STEP), 32'd0);
  endtask

  // Assert CLR with the given AB held, release it and watch warm-up.
  task automatic reset_with(input logic [1:0] ab);
    {A, B} = ab;
    CLR = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_dir", 32'(DIR), 32'd0);
    chk("rst_step", 32'(STEP), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    m_q = '0; m_dir = 1'b0; m_err = 1'b0; m_ab = ab;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      chk("warm_q", 32'(Q), 32'd0);
      chk("warm_step", 32'(STEP), 32'd0);
      chk("warm_err", 32'(ERR), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-up reset with AB = 00, then forward wrap through 16 steps.
    reset_with(2'b00);
    for (int i = 0; i < 16; i++) begin
      move({phase(m_ab) == 2'd0 ? 2'b01 :
            phase(m_ab) == 2'd1 ? 2'b11 :
            phase(m_ab) == 2'd2 ? 2'b10 : 2'b00}, "fwd");
    end
    chk("fwd_wrap_q", 32'(Q), 32'd0);

    // Reverse wrap and direction changes.
    move(2'b10, "rev_wrap");
    chk("rev_wrap_q15", 32'(Q), 32'd15);
    move(2'b00, "dchg_f1");
    move(2'b01, "dchg_f2");
    move(2'b11, "dchg_f3");
    chk("dchg_q2", 32'(Q), 32'd2);
    move(2'b01, "dchg_r1");
    move(2'b00, "dchg_r2");
    chk("dchg_q0_dir", 32'({Q, DIR}), 32'({4'd0, 1'b1}));

    // Climb to Q = 9, then pulse CLR between clock edges.
    move(2'b01, "up9"); move(2'b11, "up9"); move(2'b10, "up9");
    move(2'b00, "up9"); move(2'b01, "up9"); move(2'b11, "up9");
    move(2'b10, "up9"); move(2'b00, "up9"); move(2'b01, "up9");
    chk("pre_async_q9", 32'(Q), 32'd9);
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    chk("async_q", 32'(Q), 32'd0);
    chk("async_dir", 32'(DIR), 32'd0);
    chk("async_err", 32'(ERR), 32'd0);
    #1;
    CLR = 1'b0;
    m_q = '0; m_dir = 1'b0; m_err = 1'b0;

    // Reset with both phases high, then 11 -> 10 counts once.
    reset_with(2'b11);
    move(2'b10, "after_rst11");
    chk("after_rst11_q1", 32'(Q), 32'd1);

    // Reset at AB = 10, walk to Q = 5 at AB = 00, then an illegal jump.
    reset_with(2'b10);
    move(2'b00, "to5"); move(2'b01, "to5"); move(2'b11, "to5");
    move(2'b10, "to5"); move(2'b00, "to5");
    chk("at_q5", 32'(Q), 32'd5);
    move(2'b11, "illegal");
    move(2'b10, "post_err_f");
    move(2'b11, "post_err_r");
    move(2'b01, "post_err_r2");
    chk("err_sticky", 32'(ERR), 32'd1);

    // ERR clears only through CLR.
    reset_with(2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
